// File: rtl/decode_stage.sv
// decode_stage: registered, handshaked instruction decode.
// Splits fields, classifies, flags load-use hazards with one bubble.
module decode_stage #(
  parameter int DBITS   = 32,
  parameter int OPBITS  = 8,
  parameter int REGBITS = 4,
  parameter int IMMBITS = 16,
  parameter int SEXT    = 1,
  parameter int CNTBITS = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DBITS-1:0]   in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPBITS-1:0]  opcode,
  output logic [REGBITS-1:0] rd,
  output logic [REGBITS-1:0] rs1,
  output logic [REGBITS-1:0] rs2,
  output logic [DBITS-1:0]   imm,
  output logic               wr_en,
  output logic               is_load,
  output logic               uses_rs1,
  output logic               uses_rs2,
  output logic [CNTBITS-1:0] stall_cnt
);

  localparam int AHI = DBITS - OPBITS - 1;
  localparam int BHI = AHI - REGBITS;
  localparam int CHI = BHI - REGBITS;

  typedef struct packed {
    logic [OPBITS-1:0]  opcode;
    logic [REGBITS-1:0] rd;
    logic [REGBITS-1:0] rs1;
    logic [REGBITS-1:0] rs2;
    logic [DBITS-1:0]   imm;
    logic               wr_en;
    logic               is_load;
    logic               uses_rs1;
    logic               uses_rs2;
  } id_ex_t;

  id_ex_t d;
  id_ex_t q;
  logic   vld;

  logic [OPBITS-1:0]  op;
  logic [REGBITS-1:0] fa;
  logic [REGBITS-1:0] fb;
  logic [REGBITS-1:0] fc;
  logic [1:0]         cls;
  logic               sbit;
  logic [DBITS-1:0]   ext;
  logic               m1;
  logic               m2;
  logic               hazard;
  logic               accept;

  assign op   = in_instr[DBITS-1 -: OPBITS];
  assign fa   = in_instr[AHI -: REGBITS];
  assign fb   = in_instr[BHI -: REGBITS];
  assign fc   = in_instr[CHI -: REGBITS];
  assign cls  = op[OPBITS-1 -: 2];
  assign sbit = (SEXT != 0) ? in_instr[IMMBITS-1] : 1'b0;
  assign ext  = {{(DBITS-IMMBITS){sbit}}, in_instr[IMMBITS-1:0]};

  // Combinational decode of the offered instruction word
  always_comb begin
    d        = '0;
    d.opcode = op;
    unique case (1'b1)
      (cls == 2'b00): begin
        d.rd       = fa;
        d.rs1      = fb;
        d.rs2      = fc;
        d.wr_en    = 1'b1;
        d.uses_rs1 = 1'b1;
        d.uses_rs2 = 1'b1;
      end
      (cls == 2'b10): begin
        d.rd       = fa;
        d.rs1      = fb;
        d.imm      = ext;
        d.wr_en    = 1'b1;
        d.uses_rs1 = 1'b1;
      end
      (cls == 2'b01): begin
        d.rd       = fa;
        d.rs1      = fb;
        d.imm      = ext;
        d.wr_en    = 1'b1;
        d.is_load  = 1'b1;
        d.uses_rs1 = 1'b1;
      end
      (cls == 2'b11): begin
        d.rs1      = fa;
        d.rs2      = fb;
        d.imm      = ext;
        d.uses_rs1 = 1'b1;
        d.uses_rs2 = 1'b1;
      end
    endcase
  end

  assign m1 = d.uses_rs1 && (d.rs1 == q.rd);
  assign m2 = d.uses_rs2 && (d.rs2 == q.rd);

  assign hazard   = vld && q.is_load && (m1 || m2);
  assign in_ready = !flush && !hazard
                 && (!vld || out_ready);
  assign accept   = in_valid && in_ready;

  // Output register: flush squashes, accept loads, drain empties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0;
      q   <= '0;
    end else if (flush) begin
      vld <= 1'b0;
    end else if (accept) begin
      vld <= 1'b1;
      q   <= d;
    end else if (vld && out_ready) begin
      vld <= 1'b0;
    end
  end

  // Saturating count of cycles lost to load-use hazards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (!flush && in_valid && hazard
                 && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNTBITS'(1);
    end
  end

  assign out_valid = vld;
  assign opcode    = q.opcode;
  assign rd        = q.rd;
  assign rs1       = q.rs1;
  assign rs2       = q.rs2;
  assign imm       = q.imm;
  assign wr_en     = q.wr_en;
  assign is_load   = q.is_load;
  assign uses_rs1  = q.uses_rs1;
  assign uses_rs2  = q.uses_rs2;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage.
// Directed vectors; monitor pops expected records on each transfer.
module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  opcode;
  logic [3:0]  rd;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic [31:0] imm;
  logic        wr_en;
  logic        is_load;
  logic        uses_rs1;
  logic        uses_rs2;
  logic [15:0] stall_cnt;

  logic        d1_in_ready;
  logic        d1_out_valid;
  logic [7:0]  d1_opcode;
  logic [3:0]  d1_rd;
  logic [3:0]  d1_rs1;
  logic [3:0]  d1_rs2;
  logic [31:0] d1_imm;
  logic        d1_wr_en;
  logic        d1_is_load;
  logic        d1_uses_rs1;
  logic        d1_uses_rs2;
  logic [1:0]  d1_stall_cnt;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .wr_en(wr_en), .is_load(is_load),
    .uses_rs1(uses_rs1), .uses_rs2(uses_rs2),
    .stall_cnt(stall_cnt)
  );

  decode_stage #(.SEXT(0), .CNTBITS(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(d1_in_ready),
    .in_instr(in_instr),
    .out_valid(d1_out_valid), .out_ready(out_ready),
    .opcode(d1_opcode), .rd(d1_rd), .rs1(d1_rs1),
    .rs2(d1_rs2), .imm(d1_imm), .wr_en(d1_wr_en),
    .is_load(d1_is_load), .uses_rs1(d1_uses_rs1),
    .uses_rs2(d1_uses_rs2), .stall_cnt(d1_stall_cnt)
  );

  typedef struct {
    logic [7:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [31:0] imm;
    logic        wr;
    logic        ld;
    logic        u1;
    logic        u2;
    string       nm;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(
    input logic [7:0] op, input logic [3:0] rd_,
    input logic [3:0] s1, input logic [3:0] s2,
    input logic [31:0] im, input logic wr,
    input logic ld, input logic u1, input logic u2,
    input string nm);
    exp_t e;
    e.op = op; e.rd = rd_; e.rs1 = s1; e.rs2 = s2;
    e.imm = im; e.wr = wr; e.ld = ld;
    e.u1 = u1; e.u2 = u2; e.nm = nm;
    return e;
  endfunction

  function automatic logic [56:0] pk(
    input logic v, input logic [7:0] op,
    input logic [3:0] rd_, input logic [3:0] s1,
    input logic [3:0] s2, input logic [31:0] im,
    input logic wr, input logic ld,
    input logic u1, input logic u2);
    return {v, op, rd_, s1, s2, im, wr, ld, u1, u2};
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic send(input logic [31:0] ins,
                      input exp_t e, output int waits);
    logic acc;
    logic got;
    waits = 0;
    got = 1'b0;
    in_valid = 1'b1;
    in_instr = ins;
    while (!got && waits < 20) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) got = 1'b1;
      else waits++;
    end
    in_valid = 1'b0;
    if (got) sbq.push_back(e);
    else begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=stuck required=%h",
               ins);
    end
  endtask

  // Monitor: every transfer pops one expected record
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%h required=none",
                 {opcode, rd, rs1, rs2, imm});
      end else begin
        e = sbq.pop_front();
        chk({"out_", e.nm},
            64'(pk(out_valid, opcode, rd, rs1, rs2, imm,
                   wr_en, is_load, uses_rs1, uses_rs2)),
            64'(pk(1'b1, e.op, e.rd, e.rs1, e.rs2, e.imm,
                   e.wr, e.ld, e.u1, e.u2)));
        chk({"zext_", e.nm},
            64'(pk(d1_out_valid, d1_opcode, d1_rd, d1_rs1,
                   d1_rs2, d1_imm, d1_wr_en, d1_is_load,
                   d1_uses_rs1, d1_uses_rs2)),
            64'(pk(1'b1, e.op, e.rd, e.rs1, e.rs2,
                   {16'h0, e.imm[15:0]},
                   e.wr, e.ld, e.u1, e.u2)));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    exp_t er1, eld5, edep, end6, est, eld7;
    exp_t eit, eld0, ei12, er0;
    int w;
    er1  = mk(8'h00, 3, 1, 2, 32'h0, 1, 0, 1, 1, "r1");
    eld5 = mk(8'h40, 5, 2, 0, 32'hFFFFFFFC, 1, 1, 1, 0, "ld5");
    edep = mk(8'h00, 6, 5, 1, 32'h0, 1, 0, 1, 1, "dep");
    end6 = mk(8'h00, 6, 1, 2, 32'h0, 1, 0, 1, 1, "nodep");
    est  = mk(8'hC0, 0, 5, 7, 32'h10, 0, 0, 1, 1, "st");
    eld7 = mk(8'h40, 7, 0, 0, 32'h4, 1, 1, 1, 0, "ld7");
    eit  = mk(8'h80, 10, 3, 0, 32'hFFFF8000, 1, 0, 1, 0, "ineg");
    eld0 = mk(8'h40, 0, 0, 0, 32'h4, 1, 1, 1, 0, "ld0");
    ei12 = mk(8'h80, 1, 2, 0, 32'h0, 1, 0, 1, 0, "i12");
    er0  = mk(8'h00, 1, 0, 2, 32'h0, 1, 0, 1, 1, "r0src");

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_instr = 32'h0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    chk("rst_fields", 64'({opcode, rd, rs1, rs2, imm,
        wr_en, is_load, uses_rs1, uses_rs2}), 64'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", 64'(in_ready), 64'd1);

    // 1: R-type, one-cycle latency
    send(32'h00312000, er1, w);
    chk("t1_wait", 64'(w), 64'd0);
    @(negedge clk);
    chk("t1_latency", 64'(out_valid), 64'd1);
    @(posedge clk); #1;

    // 2: sign vs zero extension
    send(32'h4052FFFC, eld5, w);
    @(negedge clk);
    chk("t2_zext_ld", 64'(d1_imm), 64'h0000FFFC);
    @(posedge clk); #1;
    send(32'h80A38000, eit, w);
    @(negedge clk);
    chk("t2_zext_i", 64'(d1_imm), 64'h00008000);
    @(posedge clk); #1;

    // 3: load-use bubble, then non-dependent stream
    send(32'h4052FFFC, eld5, w);
    chk("t3_ld_wait", 64'(w), 64'd0);
    send(32'h00651000, edep, w);
    chk("t3_dep_wait", 64'(w), 64'd1);
    @(negedge clk);
    chk("t3_dep_valid", 64'(out_valid), 64'd1);
    chk("t3_stall", 64'(stall_cnt), 64'd1);
    @(posedge clk); #1;
    send(32'h4052FFFC, eld5, w);
    send(32'h00612000, end6, w);
    chk("t3_nodep_wait", 64'(w), 64'd0);
    chk("t3_nodep_stall", 64'(stall_cnt), 64'd1);

    // 4: store, then store after load of rs2
    send(32'hC0570010, est, w);
    chk("t4_st_wait", 64'(w), 64'd0);
    send(32'h40700004, eld7, w);
    send(32'hC0570010, est, w);
    chk("t4_st_hz_wait", 64'(w), 64'd1);
    chk("t4_stall", 64'(stall_cnt), 64'd2);

    // register 0 compares like any other
    send(32'h40000004, eld0, w);
    send(32'h80120000, ei12, w);
    chk("r0_i_wait", 64'(w), 64'd0);
    send(32'h40000004, eld0, w);
    send(32'h00102000, er0, w);
    chk("r0_hz_wait", 64'(w), 64'd1);
    chk("r0_stall", 64'(stall_cnt), 64'd3);

    // 5: backpressure holds outputs for 4 cycles
    send(32'h00312000, er1, w);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h00612000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_ready", 64'({in_ready, d1_in_ready}), 64'd0);
      chk("t5_hold",
          64'(pk(out_valid, opcode, rd, rs1, rs2, imm,
                 wr_en, is_load, uses_rs1, uses_rs2)),
          64'(pk(1'b1, er1.op, er1.rd, er1.rs1, er1.rs2,
                 er1.imm, er1.wr, er1.ld, er1.u1, er1.u2)));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(32'h00612000, end6, w);
    chk("t5_resume_wait", 64'(w), 64'd0);

    // 6: flush while load held and dependent waiting
    send(32'h4052FFFC, eld5, w);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h00651000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t6_hz_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    chk("t6_flush_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("t6_flush_valid", 64'(out_valid), 64'd0);
    chk("t6_flush_stall", 64'(stall_cnt), 64'd5);
    void'(sbq.pop_back());
    out_ready = 1'b1;
    send(32'h00651000, edep, w);
    chk("t6_after_wait", 64'(w), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("drain_empty", 64'(sbq.size()), 64'd0);
    chk("stall_total", 64'(stall_cnt), 64'd5);
    chk("stall_sat", 64'(d1_stall_cnt), 64'd3);

    // reset mid-hazard
    send(32'h4052FFFC, eld5, w);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h00651000;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 64'({out_valid, d1_out_valid}), 64'd0);
    chk("rst_mid_stall", 64'({stall_cnt, d1_stall_cnt}), 64'd0);
    chk("rst_mid_fields", 64'({rd, rs1, imm, is_load}), 64'd0);
    sbq.delete();
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(32'h00651000, edep, w);
    chk("rst_dep_wait", 64'(w), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("end_empty", 64'(sbq.size()), 64'd0);
    chk("end_stall", 64'(stall_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
